// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// `ISIZE sets the instruction width and defaults to 32 bits.
`ifndef ISIZE
`define ISIZE 32
`endif

package fetch_pkg;
   localparam int FIFO_DEPTH_DEFAULT = 4;
   localparam int AW_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef logic [`ISIZE-1:0] inst_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port plus decode handshake, grouped for the fetch unit.
interface fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int AW = AW_DEFAULT
);
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   inst_t         imem_rdata;
   inst_t         inst;
   logic [AW-1:0] inst_pc;
   logic          inst_valid;
   logic          inst_ready;

   modport master (
      output imem_en, imem_addr, inst, inst_pc, inst_valid,
      input  imem_rdata, inst_ready
   );

   modport slave (
      input  imem_en, imem_addr, inst, inst_pc, inst_valid,
      output imem_rdata, inst_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries; the head is presented combinationally
// and forced to zero while the buffer is empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int AW    = AW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [AW-1:0]          push_pc,
   input  inst_t                  push_inst,
   input  logic                   pop,
   output logic                   head_valid,
   output logic [AW-1:0]          head_pc,
   output inst_t                  head_inst,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + $bits(inst_t);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [EW-1:0] head;

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {push_pc, push_inst};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head       = mem[rd_ptr];
   assign head_valid = (count != '0);
   assign head_pc    = head_valid ? head[EW-1 -: AW] : '0;
   assign head_inst  = head_valid ? head[$bits(inst_t)-1:0] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher feeding a small decode buffer.
// Defining FETCH_PERF_EN adds the stall_cycles performance counter output.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int AW         = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] prog_len,
   fetch_unit_if.master  bus,
   output logic          busy,
   output logic          done
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   stall_cycles
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] len_q;
   logic [AW-1:0] ret_pc;
   logic          imem_en_q;
   logic          rd_pending;
   logic          done_q;
   logic          push;
   logic          pop;
   logic          head_valid;
   logic [AW-1:0] head_pc;
   inst_t         head_inst;
   logic [CW-1:0] fifo_count;
   logic [OW-1:0] count_next;
   logic [OW-1:0] occ_next;

   assign push       = rd_pending;
   assign pop        = head_valid && bus.inst_ready;
   assign pc_next    = pc + AW'(imem_en_q);
   assign count_next = {1'b0, fifo_count} + OW'(push) - OW'(pop);
   // Next cycle's buffer slots plus the read that will be returning then.
   assign occ_next   = count_next + OW'(imem_en_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         len_q      <= '0;
         ret_pc     <= '0;
         imem_en_q  <= 1'b0;
         rd_pending <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rd_pending <= imem_en_q;
         ret_pc     <= pc;
         case (state)
            IDLE: begin
               if (start) begin
                  pc        <= '0;
                  len_q     <= prog_len;
                  done_q    <= (prog_len == '0);
                  imem_en_q <= (prog_len != '0);
                  if (prog_len != '0) begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               pc <= pc_next;
               if (pc_next == len_q) begin
                  state     <= DRAIN;
                  imem_en_q <= 1'b0;
               end else begin
                  imem_en_q <= (occ_next < OW'(FIFO_DEPTH));
               end
            end
            DRAIN: begin
               imem_en_q <= 1'b0;
               if ((count_next == '0) && !imem_en_q) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               imem_en_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_pc    (ret_pc),
      .push_inst  (bus.imem_rdata),
      .pop        (pop),
      .head_valid (head_valid),
      .head_pc    (head_pc),
      .head_inst  (head_inst),
      .count      (fifo_count)
   );

   assign bus.imem_en    = imem_en_q;
   assign bus.imem_addr  = pc;
   assign bus.inst       = head_inst;
   assign bus.inst_pc    = head_pc;
   assign bus.inst_valid = head_valid;
   assign busy           = (state != IDLE);
   assign done           = done_q;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || ((state == IDLE) && start)) begin
         stall_cycles <= '0;
      end else if (head_valid && !bus.inst_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, inst} pairs are queued when a
// run is started and compared as decode accepts them.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] pc;
      inst_t         inst;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] prog_len = '0;
   logic          busy;
   logic          done;
`ifdef FETCH_PERF_EN
   logic [31:0]   stall_cycles;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   int   en_pulses = 0;
   exp_t exp_q[$];
   logic prev_stalled = 1'b0;
   exp_t prev_head;

   fetch_unit_if #(.AW(AW)) bus();

   fetch_unit #(
      .FIFO_DEPTH (4),
      .AW         (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .prog_len (prog_len),
      .bus      (bus),
      .busy     (busy),
      .done     (done)
`ifdef FETCH_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic inst_t mem_word(input logic [AW-1:0] a);
      return inst_t'(a) + inst_t'(1);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Starts a run and queues the instructions it should deliver; returns in cycle 1.
   task automatic applyStimulus(input logic [AW-1:0] len);
      @(posedge clk);
      #1;
      start    = 1'b1;
      prog_len = len;
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back({AW'(i), mem_word(AW'(i))});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget, input string tag);
      int n;
      n = 0;
      while (!done && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 64'(done), 64'd1);
   endtask

   always @(posedge clk) begin
      bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : inst_t'(32'hDEADBEEF);
   end

   // Decode-side monitor: scoreboard pops and head stability under back-pressure.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stalled = 1'b0;
      end else begin
         if (bus.imem_en) en_pulses++;
         if (prev_stalled && bus.inst_valid) begin
            checkOutput("hold", 64'({bus.inst_pc, bus.inst}), 64'(prev_head));
         end
         if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious", 64'({bus.inst_pc, bus.inst}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               checkOutput("deliver", 64'({bus.inst_pc, bus.inst}), 64'(e));
            end
         end
         prev_stalled = bus.inst_valid && !bus.inst_ready;
         prev_head    = {bus.inst_pc, bus.inst};
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.inst_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_imem_en", 64'(bus.imem_en), 64'd0);
      checkOutput("rst_addr", 64'(bus.imem_addr), 64'd0);
      checkOutput("rst_valid", 64'(bus.inst_valid), 64'd0);
      checkOutput("rst_inst", 64'({bus.inst_pc, bus.inst}), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] latency and throughput, prog_len=5");
      applyStimulus(AW'(5));
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checkOutput("lat_en", 64'(bus.imem_en), 64'd1);
            checkOutput("lat_addr", 64'(bus.imem_addr), 64'd0);
         end
         if (cyc == 2) checkOutput("lat_valid_early", 64'(bus.inst_valid), 64'd0);
         if ((cyc >= 3) && (cyc <= 7)) begin
            checkOutput("tput_valid", 64'(bus.inst_valid), 64'd1);
            checkOutput("tput_pc", 64'(bus.inst_pc), 64'(cyc - 3));
         end
         checkOutput("done_time", 64'(done), 64'(cyc == 8));
      end
      checkOutput("busy_after5", 64'(busy), 64'd0);
      checkOutput("sb_empty5", 64'(exp_q.size()), 64'd0);

      $display("[TB] back-pressure, prog_len=10");
      bus.inst_ready = 1'b0;
      en_pulses = 0;
      applyStimulus(AW'(10));
      repeat (20) @(negedge clk);
      checkOutput("bp_en_pulses", 64'(en_pulses), 64'd4);
      checkOutput("bp_valid", 64'(bus.inst_valid), 64'd1);
      checkOutput("bp_pc", 64'(bus.inst_pc), 64'd0);
      @(posedge clk);
      #1 bus.inst_ready = 1'b1;
      waitDone(60, "bp_done");
      checkOutput("bp_en_total", 64'(en_pulses), 64'd10);
      checkOutput("sb_empty10", 64'(exp_q.size()), 64'd0);

      $display("[TB] random ready, prog_len=64, stray start while busy");
      applyStimulus(AW'(64));
      for (int cyc = 0; (cyc < 2000) && !done; cyc++) begin
         @(posedge clk);
         #1;
         bus.inst_ready = 1'($urandom_range(0, 1));
         start          = (cyc == 10);
         prog_len       = (cyc == 10) ? AW'(3) : AW'(0);
      end
      start = 1'b0;
      checkOutput("rand_done", 64'(done), 64'd1);
      checkOutput("sb_empty64", 64'(exp_q.size()), 64'd0);
      bus.inst_ready = 1'b1;

      $display("[TB] reset in cycle 5 of a 20-instruction run");
      applyStimulus(AW'(20));
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      en_pulses = 0;
      @(negedge clk);
      checkOutput("mrst_imem_en", 64'(bus.imem_en), 64'd0);
      checkOutput("mrst_valid", 64'(bus.inst_valid), 64'd0);
      checkOutput("mrst_inst", 64'({bus.inst_pc, bus.inst}), 64'd0);
      checkOutput("mrst_busy", 64'(busy), 64'd0);
      checkOutput("mrst_done", 64'(done), 64'd0);
      repeat (10) begin
         @(negedge clk);
         checkOutput("mrst_quiet", 64'(bus.inst_valid), 64'd0);
      end
      checkOutput("mrst_no_reads", 64'(en_pulses), 64'd0);

      $display("[TB] empty program");
      en_pulses = 0;
      applyStimulus(AW'(0));
      @(negedge clk);
      checkOutput("len0_done", 64'(done), 64'd1);
      checkOutput("len0_busy", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("len0_no_reads", 64'(en_pulses), 64'd0);

      $display("[TB] fresh run after reset");
      applyStimulus(AW'(3));
      waitDone(30, "post_rst_done");
      checkOutput("sb_empty3", 64'(exp_q.size()), 64'd0);

`ifdef FETCH_PERF_EN
      $display("[TB] stall counter");
      bus.inst_ready = 1'b0;
      applyStimulus(AW'(3));
      begin
         int n;
         n = 0;
         while (!bus.inst_valid && (n < 10)) begin
            @(negedge clk);
            n++;
         end
         checkOutput("perf_valid", 64'(bus.inst_valid), 64'd1);
      end
      repeat (7) @(posedge clk);
      #1 bus.inst_ready = 1'b1;
      waitDone(30, "perf_done");
      checkOutput("perf_stalls", 64'(stall_cycles), 64'd7);
      applyStimulus(AW'(2));
      @(negedge clk);
      checkOutput("perf_clear", 64'(stall_cycles), 64'd0);
      waitDone(30, "perf_done2");
      checkOutput("sb_empty_perf", 64'(exp_q.size()), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 FIFO_DEPTH, 4, instruction buffer entries (power of two, >= 2).
REQ-002 AW, 8, instruction-memory address width.
REQ-003 clk  input  1  rising-edge clock; only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begin fetch at address 0.
REQ-006 prog_len  input  AW  instruction count; fetch stops when PC == prog_len; sampled with start.
REQ-007 imem_en  output  1  instruction-memory read request.
REQ-008 imem_addr  output  AW  read address, valid when imem_en=1.
REQ-009 imem_rdata  input  `ISIZE  read data, valid exactly one cycle after imem_en.
REQ-010 inst  output  `ISIZE  head-of-buffer instruction to decode.
REQ-011 inst_pc  output  AW  address of inst.
REQ-012 inst_valid  output  1  inst/inst_pc valid.
REQ-013 inst_ready  input  1  decode accepts inst.
REQ-014 busy  output  1  state != IDLE.
REQ-015 done  output  1  sticky; program fully delivered.

Function
REQ-016 States IDLE, RUN, DRAIN; IDLE->RUN on start with prog_len != 0; start with prog_len == 0 -> done=1, stay IDLE.
REQ-017 RUN: imem_en=1 iff PC < prog_len_q and (fifo_count + inflight) < FIFO_DEPTH; PC increments by 1 per issued read.
REQ-018 Returned word written to buffer with its PC in the cycle after imem_en; buffer can never overflow (slot reserved at issue).
REQ-019 RUN->DRAIN in the cycle after the read of address prog_len_q-1 issues; DRAIN->IDLE when buffer empty and no read in flight; done=1 on that transition.
REQ-020 Transfer occurs on inst_valid && inst_ready; inst, inst_pc held stable while inst_valid && !inst_ready.
REQ-021 Same-cycle push and pop: count unchanged, both take effect; pop from empty never occurs (inst_valid=0).
REQ-022 Read/write pointers wrap modulo FIFO_DEPTH; instructions delivered in strict PC order, none dropped or duplicated.
REQ-023 Latency: start high in cycle 0 -> imem_en, addr 0 in cycle 1 -> inst_valid, inst_pc 0 in cycle 3.
REQ-024 Throughput: with inst_ready held high, one instruction per cycle sustained.
REQ-025 start while busy=1 ignored; start in IDLE clears done and PC.

Reset
REQ-026 rst=1: state IDLE, PC 0, buffer empty, in-flight marker cleared; imem_en, inst_valid, busy, done = 0; inst, inst_pc = 0.
REQ-027 Reset mid-run: imem_rdata returned in the cycle after reset is discarded.

Configuration
REQ-028 FETCH_PERF_EN defined: extra output stall_cycles (32 bits) counts cycles with inst_valid && !inst_ready, cleared by rst and accepted start, saturates at all-ones.
REQ-029 FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg holds the state enum, inst_t typedef (`ISIZE bits), and FIFO_DEPTH default.
REQ-031 Buffer implemented as sub-module fetch_fifo (synchronous FIFO of {pc, inst}, count output).

Verification
REQ-032 prog_len=5, inst_ready=1, memory word i = i+1: inst_pc 0..4 on cycles 3..7, done=1 cycle 8.
REQ-033 prog_len=10, inst_ready=0 for 20 cycles: exactly 4 imem_en pulses, inst_pc 0 held; ready released -> remaining 6 delivered in order.
REQ-034 Random inst_ready (50%), prog_len=64: all 64 words delivered in order, no duplicates, pointers wrap repeatedly.
REQ-035 prog_len=0 start: done=1 next cycle, imem_en never asserts.
REQ-036 rst asserted cycle 5 of a 20-instruction run: all outputs 0 next cycle, no inst_valid until new start.
REQ-037 FETCH_PERF_EN: 7 stalled cycles -> stall_cycles=7; cleared on next start.
